// File: rtl/font_pkg.sv
// font_pkg: shared constants, types and the case-folding helper for the
// character-cell pixel generator.
package font_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_A       = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    // One glyph row (MSB = leftmost pixel) and one whole glyph (row 0 in the top byte).
    typedef logic [GLYPH_W-1:0]         row_byte_t;
    typedef logic [GLYPH_H*GLYPH_W-1:0] glyph_t;

    // Lowercase letters share the uppercase artwork; every other code passes through.
    function automatic logic [7:0] fold_case(input logic [7:0] code);
        if ((code >= ASCII_LOWER_A) && (code <= ASCII_LOWER_Z)) begin
            return code - CASE_OFFSET;
        end
        return code;
    endfunction

endpackage

// File: rtl/font_rom.sv
// font_rom: combinational glyph ROM for space, digits and uppercase letters.
// Each glyph is a 128-bit constant; the requested row byte is sliced out of it.
module font_rom
    import font_pkg::*;
(
    input  logic [7:0] i_code,
    input  logic [3:0] i_row,
    output row_byte_t  o_row_byte
);

    glyph_t     w_glyph;
    logic [6:0] w_base;

    // Glyph lookup; codes outside the drawable set (space included) fall through to blank.
    always_comb begin
        w_glyph = '0;
        case (i_code)
            8'h30: w_glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000; // 0
            8'h31: w_glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000; // 1
            8'h32: w_glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000; // 2
            8'h33: w_glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000; // 3
            8'h34: w_glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000; // 4
            8'h35: w_glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000; // 5
            8'h36: w_glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000; // 6
            8'h37: w_glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000; // 7
            8'h38: w_glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000; // 8
            8'h39: w_glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000; // 9
            8'h41: w_glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000; // A
            8'h42: w_glyph = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000; // B
            8'h43: w_glyph = 128'h0000_3C66_C2C0_C0C0_C0C2_663C_0000_0000; // C
            8'h44: w_glyph = 128'h0000_F86C_6666_6666_6666_6CF8_0000_0000; // D
            8'h45: w_glyph = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000; // E
            8'h46: w_glyph = 128'h0000_FE66_6268_7868_6060_60F0_0000_0000; // F
            8'h47: w_glyph = 128'h0000_3C66_C2C0_C0DE_C6C6_663A_0000_0000; // G
            8'h48: w_glyph = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000; // H
            8'h49: w_glyph = 128'h0000_3C18_1818_1818_1818_183C_0000_0000; // I
            8'h4A: w_glyph = 128'h0000_1E0C_0C0C_0C0C_CCCC_CC78_0000_0000; // J
            8'h4B: w_glyph = 128'h0000_E666_666C_7878_6C66_66E6_0000_0000; // K
            8'h4C: w_glyph = 128'h0000_F060_6060_6060_6062_66FE_0000_0000; // L
            8'h4D: w_glyph = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000; // M
            8'h4E: w_glyph = 128'h0000_C6E6_F6FE_DECE_C6C6_C6C6_0000_0000; // N
            8'h4F: w_glyph = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000; // O
            8'h50: w_glyph = 128'h0000_FC66_6666_7C60_6060_60F0_0000_0000; // P
            // Q's CP437 descender is dropped so rows 12-15 stay blank across the whole set.
            8'h51: w_glyph = 128'h0000_7CC6_C6C6_C6C6_C6D6_DE7C_0000_0000; // Q
            8'h52: w_glyph = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000; // R
            8'h53: w_glyph = 128'h0000_7CC6_C660_380C_06C6_C67C_0000_0000; // S
            8'h54: w_glyph = 128'h0000_7E7E_5A18_1818_1818_183C_0000_0000; // T
            8'h55: w_glyph = 128'h0000_C6C6_C6C6_C6C6_C6C6_C67C_0000_0000; // U
            8'h56: w_glyph = 128'h0000_C6C6_C6C6_C6C6_C66C_3810_0000_0000; // V
            8'h57: w_glyph = 128'h0000_C6C6_C6C6_D6D6_D6FE_EE6C_0000_0000; // W
            8'h58: w_glyph = 128'h0000_C6C6_6C7C_3838_7C6C_C6C6_0000_0000; // X
            8'h59: w_glyph = 128'h0000_6666_6666_3C18_1818_183C_0000_0000; // Y
            8'h5A: w_glyph = 128'h0000_FEC6_860C_1830_60C2_C6FE_0000_0000; // Z
            default: w_glyph = '0;
        endcase
    end

    // Row 0 sits in the top byte, so the slice base is (15 - row) * 8 = {~row, 3'b000}.
    assign w_base     = {~i_row, 3'b000};
    assign o_row_byte = w_glyph[w_base +: GLYPH_W];

endmodule

// File: rtl/font_renderer.sv
// font_renderer: turns an ASCII code plus a pixel position inside an 8x16
// cell into one foreground/background bit, optionally registered.
module font_renderer
    import font_pkg::*;
#(
    parameter bit REGISTERED = 1'b1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ascii_code,
    input  logic [3:0] row_in_char,
    input  logic [2:0] col_in_char,
    output logic       pixel_on
);

    logic [7:0] w_code;
    row_byte_t  w_row_byte;
    logic       w_pixel;

    assign w_code = fold_case(ascii_code);

    font_rom u_font_rom (
        .i_code     (w_code),
        .i_row      (row_in_char),
        .o_row_byte (w_row_byte)
    );

    // Column 0 is the MSB of the row byte, so bit index 7 - col is simply ~col.
    assign w_pixel = w_row_byte[~col_in_char];

    if (REGISTERED) begin : g_reg
        logic r_pixel;

        // Output register: one pixel per clock, cleared at once while reset is low.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pixel <= 1'b0;
            end else begin
                r_pixel <= w_pixel;
            end
        end

        assign pixel_on = r_pixel;
    end else begin : g_comb
        // Clock and reset have no role when the output is taken straight from the ROM path.
        logic w_unused_ctl;
        assign w_unused_ctl = clk ^ reset_n;
        assign pixel_on     = w_pixel;
    end

endmodule

// File: tb/tb_font_renderer.sv
// tb_font_renderer: drives a registered and a combinational instance in
// parallel and compares both against a table-driven glyph model.
module tb_font_renderer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ascii_code;
    logic [3:0] row_in_char;
    logic [2:0] col_in_char;
    logic       pixel_reg;
    logic       pixel_comb;

    int n_checks = 0;
    int n_errors = 0;

    logic exp_prev;
    bit   have_prev;

    always #5 clk = ~clk;

    font_renderer #(.REGISTERED(1'b1)) u_dut_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .ascii_code  (ascii_code),
        .row_in_char (row_in_char),
        .col_in_char (col_in_char),
        .pixel_on    (pixel_reg)
    );

    font_renderer #(.REGISTERED(1'b0)) u_dut_comb (
        .clk         (clk),
        .reset_n     (reset_n),
        .ascii_code  (ascii_code),
        .row_in_char (row_in_char),
        .col_in_char (col_in_char),
        .pixel_on    (pixel_comb)
    );

    // Drawable rows 2..11 of each glyph, ten bytes per glyph: '0'..'9' then 'A'..'Z'.
    localparam logic [7:0] FONT [0:359] = '{
        8'h7C,8'hC6,8'hC6,8'hCE,8'hDE,8'hF6,8'hE6,8'hC6,8'hC6,8'h7C,
        8'h18,8'h38,8'h78,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h7E,
        8'h7C,8'hC6,8'h06,8'h0C,8'h18,8'h30,8'h60,8'hC0,8'hC6,8'hFE,
        8'h7C,8'hC6,8'h06,8'h06,8'h3C,8'h06,8'h06,8'h06,8'hC6,8'h7C,
        8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h1E,
        8'hFE,8'hC0,8'hC0,8'hC0,8'hFC,8'h06,8'h06,8'h06,8'hC6,8'h7C,
        8'h38,8'h60,8'hC0,8'hC0,8'hFC,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,
        8'hFE,8'hC6,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,
        8'h7C,8'hC6,8'hC6,8'hC6,8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,
        8'h7C,8'hC6,8'hC6,8'hC6,8'h7E,8'h06,8'h06,8'h06,8'h0C,8'h78,
        8'h10,8'h38,8'h6C,8'hC6,8'hC6,8'hFE,8'hC6,8'hC6,8'hC6,8'hC6,
        8'hFC,8'h66,8'h66,8'h66,8'h7C,8'h66,8'h66,8'h66,8'h66,8'hFC,
        8'h3C,8'h66,8'hC2,8'hC0,8'hC0,8'hC0,8'hC0,8'hC2,8'h66,8'h3C,
        8'hF8,8'h6C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h6C,8'hF8,
        8'hFE,8'h66,8'h62,8'h68,8'h78,8'h68,8'h60,8'h62,8'h66,8'hFE,
        8'hFE,8'h66,8'h62,8'h68,8'h78,8'h68,8'h60,8'h60,8'h60,8'hF0,
        8'h3C,8'h66,8'hC2,8'hC0,8'hC0,8'hDE,8'hC6,8'hC6,8'h66,8'h3A,
        8'hC6,8'hC6,8'hC6,8'hC6,8'hFE,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,
        8'h3C,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h3C,
        8'h1E,8'h0C,8'h0C,8'h0C,8'h0C,8'h0C,8'hCC,8'hCC,8'hCC,8'h78,
        8'hE6,8'h66,8'h66,8'h6C,8'h78,8'h78,8'h6C,8'h66,8'h66,8'hE6,
        8'hF0,8'h60,8'h60,8'h60,8'h60,8'h60,8'h60,8'h62,8'h66,8'hFE,
        8'hC6,8'hEE,8'hFE,8'hFE,8'hD6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,
        8'hC6,8'hE6,8'hF6,8'hFE,8'hDE,8'hCE,8'hC6,8'hC6,8'hC6,8'hC6,
        8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,
        8'hFC,8'h66,8'h66,8'h66,8'h7C,8'h60,8'h60,8'h60,8'h60,8'hF0,
        8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hD6,8'hDE,8'h7C,
        8'hFC,8'h66,8'h66,8'h66,8'h7C,8'h6C,8'h66,8'h66,8'h66,8'hE6,
        8'h7C,8'hC6,8'hC6,8'h60,8'h38,8'h0C,8'h06,8'hC6,8'hC6,8'h7C,
        8'h7E,8'h7E,8'h5A,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h3C,
        8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,
        8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h6C,8'h38,8'h10,
        8'hC6,8'hC6,8'hC6,8'hC6,8'hD6,8'hD6,8'hD6,8'hFE,8'hEE,8'h6C,
        8'hC6,8'hC6,8'h6C,8'h7C,8'h38,8'h38,8'h7C,8'h6C,8'hC6,8'hC6,
        8'h66,8'h66,8'h66,8'h66,8'h3C,8'h18,8'h18,8'h18,8'h18,8'h3C,
        8'hFE,8'hC6,8'h86,8'h0C,8'h18,8'h30,8'h60,8'hC2,8'hC6,8'hFE
    };

    // Reference pixel: fold lowercase, map code to a glyph number, read the bit.
    function automatic logic model_pixel(input logic [7:0] code, input logic [3:0] row,
                                         input logic [2:0] col);
        int c;
        int g;
        logic [7:0] b;
        c = int'(code);
        if (c >= 'h61 && c <= 'h7A) c = c - 'h20;
        if (c >= 'h30 && c <= 'h39) g = c - 'h30;
        else if (c >= 'h41 && c <= 'h5A) g = 10 + c - 'h41;
        else return 1'b0;
        if (int'(row) < 2 || int'(row) > 11) return 1'b0;
        b = FONT[g * 10 + int'(row) - 2];
        return b[7 - int'(col)];
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b expected=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check the registered output for the previous inputs, then apply new ones.
    task automatic apply(input logic [7:0] c, input logic [3:0] r, input logic [2:0] k);
        logic e;
        @(posedge clk);
        #1;
        if (have_prev) check("reg_latency", pixel_reg, exp_prev);
        ascii_code  = c;
        row_in_char = r;
        col_in_char = k;
        #1;
        e = model_pixel(c, r, k);
        check($sformatf("comb code=%h row=%0d col=%0d", c, r, k), pixel_comb, e);
        if (have_prev) check("reg_hold", pixel_reg, exp_prev);
        exp_prev  = e;
        have_prev = 1'b1;
    endtask

    task automatic flush();
        @(posedge clk);
        #1;
        if (have_prev) check("reg_flush", pixel_reg, exp_prev);
        have_prev = 1'b0;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [7:0] pat;
        logic [7:0] blanks [4];
        logic [7:0] c;
        string      s;

        have_prev   = 1'b0;
        exp_prev    = 1'b0;
        reset_n     = 1'b0;
        ascii_code  = 8'h48;
        row_in_char = 4'd6;
        col_in_char = 3'd0;

        // Reset held with a lit pixel on the inputs.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", pixel_reg, 1'b0);
        check("comb_ignores_reset", pixel_comb, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset_release_no_edge", pixel_reg, 1'b0);
        @(posedge clk);
        #1;
        check("first_after_reset", pixel_reg, 1'b1);
        exp_prev  = model_pixel(8'h48, 4'd6, 3'd0);
        have_prev = 1'b1;

        // 'H' rows 6, 2 and 0 against the known row bytes.
        pat = 8'hFE;
        for (int k = 0; k < 8; k++) begin
            apply(8'h48, 4'd6, 3'(k));
            check($sformatf("H_row6_col%0d", k), pixel_comb, pat[7-k]);
        end
        pat = 8'hC6;
        for (int k = 0; k < 8; k++) begin
            apply(8'h48, 4'd2, 3'(k));
            check($sformatf("H_row2_col%0d", k), pixel_comb, pat[7-k]);
        end
        for (int k = 0; k < 8; k++) begin
            apply(8'h48, 4'd0, 3'(k));
            check($sformatf("H_row0_col%0d", k), pixel_comb, 1'b0);
        end

        // 'A' and lowercase 'a' sample points.
        for (int u = 0; u < 2; u++) begin
            c = (u == 0) ? 8'h41 : 8'h61;
            apply(c, 4'd2, 3'd3);
            check($sformatf("A_%h_r2c3", c), pixel_comb, 1'b1);
            apply(c, 4'd2, 3'd2);
            check($sformatf("A_%h_r2c2", c), pixel_comb, 1'b0);
            apply(c, 4'd7, 3'd6);
            check($sformatf("A_%h_r7c6", c), pixel_comb, 1'b1);
        end

        // Blank codes across the whole cell.
        blanks[0] = 8'h00;
        blanks[1] = 8'h20;
        blanks[2] = 8'h7F;
        blanks[3] = 8'hFF;
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 16; r++) begin
                for (int k = 0; k < 8; k++) begin
                    apply(blanks[b], 4'(r), 3'(k));
                    check($sformatf("blank_%h", blanks[b]), pixel_comb, 1'b0);
                end
            end
        end

        // Code changes every clock across a text string.
        s = "HOLA SANTIAGO";
        for (int rep = 0; rep < 8; rep++) begin
            for (int i = 0; i < s.len(); i++) begin
                apply(s[i], 4'($urandom_range(2, 11)), 3'($urandom));
            end
        end

        // Full sweep of every code and position.
        for (int code = 0; code < 256; code++) begin
            for (int r = 0; r < 16; r++) begin
                for (int k = 0; k < 8; k++) begin
                    apply(8'(code), 4'(r), 3'(k));
                end
            end
        end

        // Mid-stream reset during a run of lit pixels.
        for (int k = 0; k < 4; k++) apply(8'h48, 4'd6, 3'(k));
        @(posedge clk);
        #1;
        check("mid_before_reset", pixel_reg, exp_prev);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_async_clear", pixel_reg, 1'b0);
        check("mid_comb_unaffected", pixel_comb, 1'b1);
        #2;
        reset_n = 1'b1;
        #1;
        check("mid_released_no_edge", pixel_reg, 1'b0);
        @(posedge clk);
        #1;
        check("mid_resume", pixel_reg, 1'b1);
        exp_prev  = model_pixel(8'h48, 4'd6, 3'd3);
        have_prev = 1'b1;

        // Randomized traffic biased toward drawable codes.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       c = 8'($urandom_range('h30, 'h39));
                1:       c = 8'($urandom_range('h41, 'h5A));
                2:       c = 8'($urandom_range('h61, 'h7A));
                default: c = 8'($urandom);
            endcase
            apply(c, 4'($urandom), 3'($urandom));
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
